// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, addresses a combinational instruction memory and
// registers each word with its PC into a one-entry valid/ready output slot.
// Latency: pc -> out_instruction is 1 cycle; throughput is 1 word/cycle.
// Backpressure: while out_valid && !out_ready the slot and the PC hold; a
// branch redirect flushes the slot and costs one bubble.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   fetch_enable      - gates issue of new fetches
//   branch_valid      - one-cycle redirect request, new PC in branch_target
//   imem_address      - word address to instruction memory (== pc)
//   imem_instruction  - word returned combinationally for imem_address
//   out_valid/out_ready/out_instruction/out_pc - decoder-side slot
//   perf_fetch_count, perf_stall_count - only when FETCH_PERF_EN is defined
//
// Optional build macro: FETCH_PERF_EN adds the two performance counters.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_enable,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_stall_count
`endif
);

  logic [31:0] pc;
  logic        slot_free;
  logic        do_redirect;
  logic        do_fetch;
  logic        do_drain;
  logic        is_stall;

  // The memory sees the registered PC only, so no input reaches an output
  // combinationally.
  assign imem_address = pc;

  // Per-edge action decode. The redirect outranks everything, including a
  // handshake that would otherwise complete this cycle: the flushed word is
  // dropped, not transferred.
  always_comb begin
    slot_free   = !out_valid || out_ready;
    do_redirect = branch_valid;
    do_fetch    = !branch_valid && fetch_enable && slot_free;
    do_drain    = !branch_valid && !fetch_enable && out_valid && out_ready;
    is_stall    = out_valid && !out_ready && !branch_valid;
  end

  // PC register. Addition wraps modulo 2^32 by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (do_redirect) begin
      pc <= branch_target;
    end else if (do_fetch) begin
      pc <= pc + PC_STEP;
    end
  end

  // Output slot valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (do_redirect) begin
      out_valid <= 1'b0;
    end else if (do_fetch) begin
      out_valid <= 1'b1;
    end else if (do_drain) begin
      out_valid <= 1'b0;
    end
  end

  // Output slot payload. Only a fetch overwrites it; a flush or drain leaves
  // the stale word in place behind out_valid = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_instruction <= 32'h0;
      out_pc          <= 32'h0;
    end else if (do_fetch) begin
      out_instruction <= imem_instruction;
      out_pc          <= pc;
    end
  end

`ifdef FETCH_PERF_EN
  // Event counters, free-running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_count <= 32'h0;
      perf_stall_count <= 32'h0;
    end else begin
      if (do_fetch) begin
        perf_fetch_count <= perf_fetch_count + 32'd1;
      end
      if (is_stall) begin
        perf_stall_count <= perf_stall_count + 32'd1;
      end
    end
  end
`else
  // Stall decode only feeds the counters; keep it referenced.
  logic unused_stall;
  assign unused_stall = is_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit.
// Memory is modelled combinationally in the bench; every expected value is a
// hand-derived constant or comes from the bench memory function.

module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_enable;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_count;
  logic [31:0] perf_stall_count;
`endif

  int n_vec;
  int n_miss;

  fetch_unit #(
    .RESET_PC(32'h00000000),
    .PC_STEP (32'd1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_enable    (fetch_enable),
    .branch_valid    (branch_valid),
    .branch_target   (branch_target),
    .imem_address    (imem_address),
    .imem_instruction(imem_instruction),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_count(perf_fetch_count),
    .perf_stall_count(perf_stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: four fixed words, then a recognisable pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   mem_word = 32'h00000123;
      32'd1:   mem_word = 32'h00000321;
      32'd2:   mem_word = 32'h00000001;
      32'd3:   mem_word = 32'h00000002;
      default: mem_word = a ^ 32'hA5A50000;
    endcase
  endfunction

  assign imem_instruction = mem_word(imem_address);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc_e,
                          input logic [31:0] ins_e, input logic [31:0] addr_e);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
    chk({tag, ".pc"},    out_pc,          pc_e);
    chk({tag, ".ins"},   out_instruction, ins_e);
    chk({tag, ".addr"},  imem_address,    addr_e);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst           = 1'b1;
    fetch_enable  = 1'b1;
    out_ready     = 1'b1;
    branch_valid  = 1'b0;
    branch_target = 32'h0;

    // Reset state
    #12;
    chk_slot("reset", 1'b0, 32'h0, 32'h0, 32'h0);
`ifdef FETCH_PERF_EN
    chk("reset.pfc", perf_fetch_count, 32'h0);
    chk("reset.psc", perf_stall_count, 32'h0);
`endif
    rst = 1'b0;

    // Stream: first edge after release fetches RESET_PC
    step();
    chk_slot("s0", 1'b1, 32'd0, 32'h00000123, 32'd1);
    step();
    chk_slot("s1", 1'b1, 32'd1, 32'h00000321, 32'd2);

    // Back-pressure for 3 cycles with out_pc = 1
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_slot("bp", 1'b1, 32'd1, 32'h00000321, 32'd2);
    end
    out_ready = 1'b1;
    step();
    chk_slot("resume", 1'b1, 32'd2, 32'h00000001, 32'd3);

    // Branch flush while slot holds pc 2 and out_ready is high
    branch_valid  = 1'b1;
    branch_target = 32'd5;
    step();
    branch_valid = 1'b0;
    chk_slot("flush", 1'b0, 32'd2, 32'h00000001, 32'd5);
    step();
    chk_slot("tgt", 1'b1, 32'd5, mem_word(32'd5), 32'd6);

    // Enable low: branch back to 2, fetch it, then drain with pc held at 3
    branch_valid  = 1'b1;
    branch_target = 32'd2;
    step();
    branch_valid = 1'b0;
    chk_slot("br2", 1'b0, 32'd5, mem_word(32'd5), 32'd2);
    step();
    chk_slot("f2", 1'b1, 32'd2, 32'h00000001, 32'd3);
    fetch_enable = 1'b0;
    step();
    chk_slot("drain", 1'b0, 32'd2, 32'h00000001, 32'd3);
    step();
    chk_slot("hold", 1'b0, 32'd2, 32'h00000001, 32'd3);

    // Wrap: branch to all-ones and fetch twice
    fetch_enable  = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 32'hFFFFFFFF;
    step();
    branch_valid = 1'b0;
    chk_slot("brw", 1'b0, 32'd2, 32'h00000001, 32'hFFFFFFFF);
    step();
    chk_slot("w0", 1'b1, 32'hFFFFFFFF, mem_word(32'hFFFFFFFF), 32'h0);
    step();
    chk_slot("w1", 1'b1, 32'h0, 32'h00000123, 32'h1);

    // Async reset in the middle of a stall, between clock edges
    out_ready = 1'b0;
    step();
    chk_slot("st", 1'b1, 32'h0, 32'h00000123, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk_slot("arst", 1'b0, 32'h0, 32'h0, 32'h0);
    #2;
    rst       = 1'b0;
    out_ready = 1'b1;

    // 5 fetches, 4 stall cycles, 5 fetches
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk_slot("stall4", 1'b1, 32'd4, mem_word(32'd4), 32'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk_slot("run10", 1'b1, 32'd9, mem_word(32'd9), 32'd10);
`ifdef FETCH_PERF_EN
    chk("perf.fetch", perf_fetch_count, 32'd10);
    chk("perf.stall", perf_stall_count, 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction memory. Holds the program counter, drives the word address into the combinational instruction memory, and registers the returned word together with its PC into a single-entry output slot with a valid/ready handshake toward the decoder. Supports back-pressure stalls, a fetch enable, and branch redirect with flush.

## Interface
- `RESET_PC`, default `32'h00000000`: PC value loaded on reset.
- `PC_STEP`, default `1`: PC increment per fetched instruction. The memory is word-indexed, so one step is one instruction.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst` input, 1: reset, asynchronous and active-high.
- `fetch_enable` input, 1: when low, no new fetch is issued.
- `branch_valid` input, 1: redirect request, valid for one cycle.
- `branch_target` input, 32: new PC when `branch_valid` is high.
- `imem_address` output, 32: word address to the instruction memory; always equals `pc`.
- `imem_instruction` input, 32: word returned combinationally for `imem_address`.
- `out_valid` output, 1: output slot holds a valid instruction.
- `out_ready` input, 1: the decoder accepts the slot this cycle.
- `out_instruction` output, 32: registered instruction word.
- `out_pc` output, 32: PC of `out_instruction`.
- `perf_fetch_count` output, 32: present only with `FETCH_PERF_EN`.
- `perf_stall_count` output, 32: present only with `FETCH_PERF_EN`.

## Operation
- **Internal state:** `pc` (32 bit) and the output slot (`out_valid`, `out_instruction`, `out_pc`).
- **Slot free:** `slot_free = !out_valid || out_ready`.
- **Handshake:** a transfer occurs on a cycle where `out_valid && out_ready`.
- **Per-edge priority:**
  1. **Redirect** (`branch_valid`):
     - `pc <= branch_target`.
     - `out_valid <= 0`, flushing the slot even if `out_ready` is high that cycle; the flushed word is not transferred.
     - `out_instruction` and `out_pc` hold their values.
  2. **Fetch** (`fetch_enable && slot_free`):
     - `out_instruction <= imem_instruction`.
     - `out_pc <= pc`.
     - `out_valid <= 1`.
     - `pc <= pc + PC_STEP`.
  3. **Drain** (`out_valid && out_ready && !fetch_enable`): `out_valid <= 0`; `pc` holds.
  4. **Stall or idle:** every register holds.
- **Stall rule:** while `out_valid && !out_ready`, `out_instruction` and `out_pc` stay stable and `pc` does not advance.
- **Arithmetic:** the PC adds modulo 2^32. `32'hFFFFFFFF + 1` wraps to 0 with no flag. Address aliasing in the memory is outside this block's concern.
- **Reset mid-operation:** asserting `rst` clears everything immediately (asynchronously), whatever the handshake state. The slot contents are lost.

## Timing
- **Reset values:**
  - `pc = RESET_PC`, so `imem_address = RESET_PC`.
  - `out_valid = 0`, `out_instruction = 0`, `out_pc = 0`.
  - Perf counters = 0.
- **First fetch:** the first rising edge after `rst` is released, with `fetch_enable` high, gives `out_valid = 1` and `out_pc = RESET_PC`.
- **Latency:** `pc` to `out_instruction` is 1 cycle.
- **Throughput:** 1 instruction per cycle while `out_ready` is held high.
- **Redirect penalty:** the cycle after `branch_valid` shows `out_valid = 0`. The following edge captures the word at `branch_target`, so there is 1 bubble.
- **Combinational paths:** `imem_address` depends only on the `pc` register. There is no combinational path from any input to any output.

## Configuration
- **`FETCH_PERF_EN` defined:** adds the `perf_fetch_count` and `perf_stall_count` ports.
  - `perf_fetch_count` increments on every edge where rule 2 fires.
  - `perf_stall_count` increments on every edge where `out_valid && !out_ready && !branch_valid`.
  - Both counters wrap modulo 2^32 and reset to 0.
- **`FETCH_PERF_EN` undefined:** the ports and counters are absent, and the rest of the behaviour is identical.

## Test plan
- **Reset and stream:** release `rst` with `fetch_enable=1` and `out_ready=1`, memory words 0..3 = `32'h00000123`, `32'h00000321`, 1, 2. Expect one word per cycle with `out_pc` = 0, 1, 2, 3 and the matching `out_instruction`.
- **Back-pressure:** drop `out_ready` for 3 cycles while `out_valid=1` and `out_pc=1`. Expect `out_pc=1`, `out_instruction=32'h00000321` and `imem_address=2` stable throughout; on resume, `out_pc=2` is delivered next.
- **Branch flush:** pulse `branch_valid` with `branch_target=5` while the slot holds `out_pc=2` and `out_ready=1`. Expect the next cycle `out_valid=0` with no transfer, then `out_pc=5`.
- **Enable and wrap:** hold `fetch_enable=0` at `pc=3`. Expect one drain, then `out_valid=0` with `pc` held. Separately, branch to `32'hFFFFFFFF` and fetch twice: expect `out_pc = 32'hFFFFFFFF` then `0`.
- **Async reset:** assert `rst` mid-stall, between clock edges. Expect `out_valid=0` and `imem_address=RESET_PC` immediately, before the next edge.
- **Perf counters (`FETCH_PERF_EN`):** run 10 fetches with 4 stall cycles. Expect `perf_fetch_count=10` and `perf_stall_count=4`.
